// File: rtl/comparador_sequencial.sv
// Sequencer for the 2-bit equality/difference comparator stage: latches two words,
// streams them one digit per cycle (LSD first) and folds the stage result into a word result.
module comparador_sequencial #(
   parameter int WIDTH      = 8,
   parameter int EARLY_EXIT = 0
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      start,
   input  logic [WIDTH-1:0]          in_a,
   input  logic [WIDTH-1:0]          in_b,
   input  logic                      in_select,
   output logic [1:0]                dig_a,
   output logic [1:0]                dig_b,
   output logic                      dig_sel,
   output logic                      dig_valid,
   input  logic                      cmp_s,
   output logic                      busy,
   output logic                      done,
   output logic                      out_s,
   output logic [$clog2(WIDTH/2):0]  dig_count
);

   localparam int NDIG = WIDTH / 2;
   localparam int CW   = $clog2(NDIG) + 1;
   localparam logic [CW-1:0] LAST = CW'(NDIG - 1);

   typedef enum logic [1:0] {S_IDLE, S_SCAN, S_DONE} state_t;

   state_t           r_state;
   state_t           w_next;
   logic [WIDTH-1:0] r_a;
   logic [WIDTH-1:0] r_b;
   logic             r_sel;
   logic             r_acc;
   logic             r_out_s;
   logic [CW-1:0]    r_idx;
   logic [CW-1:0]    r_cnt;
   logic             w_accept;
   logic             w_scan_end;
   logic             w_acc_next;
   logic [1:0]       w_dig_a;
   logic [1:0]       w_dig_b;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   // The scan ends on the last digit or, in early-exit mode, once a digit pair differs
   // (cmp_s equal to the mode bit means the word result can no longer change).
   always_comb begin
      w_next     = r_state;
      w_accept   = 1'b0;
      w_scan_end = 1'b0;
      busy       = 1'b0;
      dig_valid  = 1'b0;
      done       = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (start) begin
               w_accept = 1'b1;
               w_next   = S_SCAN;
            end
         end
         S_SCAN: begin
            busy      = 1'b1;
            dig_valid = 1'b1;
            if ((r_idx == LAST) || ((EARLY_EXIT != 0) && (cmp_s == r_sel))) begin
               w_scan_end = 1'b1;
               w_next     = S_DONE;
            end
         end
         S_DONE: begin
            done = 1'b1;
            if (start) begin
               w_accept = 1'b1;
               w_next   = S_SCAN;
            end else begin
               w_next = S_IDLE;
            end
         end
         default: w_next = S_IDLE;
      endcase
   end

   assign w_acc_next = r_sel ? (r_acc | cmp_s) : (r_acc & cmp_s);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_a     <= '0;
         r_b     <= '0;
         r_sel   <= 1'b0;
         r_acc   <= 1'b0;
         r_out_s <= 1'b0;
         r_idx   <= '0;
         r_cnt   <= '0;
      end else if (w_accept) begin
         r_a   <= in_a;
         r_b   <= in_b;
         r_sel <= in_select;
         r_acc <= ~in_select;
         r_idx <= '0;
         r_cnt <= '0;
      end else if (r_state == S_SCAN) begin
         r_acc <= w_acc_next;
         r_cnt <= r_cnt + CW'(1);
         // Index freezes on the final digit so dig_a/dig_b hold it through DONE.
         if (w_scan_end) begin
            r_out_s <= w_acc_next;
         end else begin
            r_idx <= r_idx + CW'(1);
         end
      end
   end

   always_comb begin
      w_dig_a = '0;
      w_dig_b = '0;
      for (int i = 0; i < NDIG; i++) begin
         if (r_idx == CW'(i)) begin
            w_dig_a = r_a[2*i +: 2];
            w_dig_b = r_b[2*i +: 2];
         end
      end
   end

   assign dig_a     = w_dig_a;
   assign dig_b     = w_dig_b;
   assign dig_sel   = r_sel;
   assign out_s     = r_out_s;
   assign dig_count = r_cnt;

endmodule

// File: tb/tb_comparador_sequencial.sv
// Bench for comparador_sequencial: one instance per EARLY_EXIT setting, each fed by its own
// model of the comparator stage, checked cycle by cycle against a word-level reference.
module tb_comparador_sequencial;

   logic       clk;
   logic       rst_n;
   logic       start;
   logic [7:0] in_a;
   logic [7:0] in_b;
   logic       in_select;

   logic [1:0] da0, db0, da1, db1;
   logic       ds0, dv0, bsy0, dn0, os0, cmp0;
   logic       ds1, dv1, bsy1, dn1, os1, cmp1;
   logic [2:0] dc0, dc1;

   int checks = 0;
   int errors = 0;

   // Comparator stage: "iguais" when select=0, "diferentes" when select=1.
   assign cmp0 = ds0 ? (da0 != db0) : (da0 == db0);
   assign cmp1 = ds1 ? (da1 != db1) : (da1 == db1);

   comparador_sequencial #(.WIDTH(8), .EARLY_EXIT(0)) u_ee0 (
      .clk(clk), .rst_n(rst_n), .start(start), .in_a(in_a), .in_b(in_b),
      .in_select(in_select), .dig_a(da0), .dig_b(db0), .dig_sel(ds0),
      .dig_valid(dv0), .cmp_s(cmp0), .busy(bsy0), .done(dn0), .out_s(os0),
      .dig_count(dc0)
   );

   comparador_sequencial #(.WIDTH(8), .EARLY_EXIT(1)) u_ee1 (
      .clk(clk), .rst_n(rst_n), .start(start), .in_a(in_a), .in_b(in_b),
      .in_select(in_select), .dig_a(da1), .dig_b(db1), .dig_sel(ds1),
      .dig_valid(dv1), .cmp_s(cmp1), .busy(bsy1), .done(dn1), .out_s(os1),
      .dig_count(dc1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "bench timeout");
   end

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Word-level reference: the result depends only on word equality; the scan length in
   // early-exit mode is the position of the first differing digit.
   function automatic logic ref_out(input logic [7:0] a, input logic [7:0] b, input logic sel);
      return sel ? (a != b) : (a == b);
   endfunction

   function automatic int ref_digits(input logic [7:0] a, input logic [7:0] b, input bit early);
      if (!early) return 4;
      for (int i = 0; i < 4; i++) begin
         if (((a >> (2*i)) & 8'h3) != ((b >> (2*i)) & 8'h3)) return i + 1;
      end
      return 4;
   endfunction

   task automatic check_dut(input string tag, input int c, input int d,
                            input logic [7:0] a, input logic [7:0] b, input logic sel,
                            input logic eo, input logic dv, input logic bsy, input logic dn,
                            input logic os, input logic [1:0] da, input logic [1:0] db,
                            input logic ds, input logic [2:0] dc);
      logic [7:0] ea, eb;
      int k;
      k  = (c <= d) ? c - 1 : d - 1;
      ea = (a >> (2*k)) & 8'h3;
      eb = (b >> (2*k)) & 8'h3;
      chk({tag, "_valid"}, 8'(dv), 8'(c <= d));
      chk({tag, "_busy"},  8'(bsy), 8'(c <= d));
      chk({tag, "_done"},  8'(dn), 8'(c == d + 1));
      if (c <= d) begin
         chk({tag, "_dig_a"}, 8'(da), ea);
         chk({tag, "_dig_b"}, 8'(db), eb);
         chk({tag, "_dig_sel"}, 8'(ds), 8'(sel));
      end
      if (c == d + 1) begin
         chk({tag, "_hold_dig_a"}, 8'(da), ea);
         chk({tag, "_hold_dig_b"}, 8'(db), eb);
      end
      if (c >= d + 1) begin
         chk({tag, "_out_s"}, 8'(os), 8'(eo));
         chk({tag, "_dig_count"}, 8'(dc), 8'(d));
      end
   endtask

   // One operation observed for cycles 1..N after its accept edge.
   // pre_started: start/operands already driven by the previous chained call.
   // inject: pulse start with other operands during SCAN cycle 2.
   // chain: keep start high and present the next operands so DONE accepts them.
   task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic sel,
                         input bit pre_started, input bit inject, input bit chain,
                         input logic [7:0] na, input logic [7:0] nb, input logic nsel,
                         input string tag);
      logic eo;
      int   d0, d1, last;
      eo   = ref_out(a, b, sel);
      d0   = ref_digits(a, b, 1'b0);
      d1   = ref_digits(a, b, 1'b1);
      last = chain ? 5 : 6;
      if (!pre_started) begin
         @(negedge clk);
         start = 1'b1; in_a = a; in_b = b; in_select = sel;
      end
      @(posedge clk);
      for (int c = 1; c <= last; c++) begin
         @(negedge clk);
         check_dut($sformatf("%s_ee0_c%0d", tag, c), c, d0, a, b, sel, eo,
                   dv0, bsy0, dn0, os0, da0, db0, ds0, dc0);
         check_dut($sformatf("%s_ee1_c%0d", tag, c), c, d1, a, b, sel, eo,
                   dv1, bsy1, dn1, os1, da1, db1, ds1, dc1);
         if (c == 1) begin
            if (chain) begin
               in_a = na; in_b = nb; in_select = nsel;
            end else begin
               start = 1'b0;
            end
         end
         if (inject && c == 2) begin
            start = 1'b1; in_a = 8'hFF; in_b = 8'h00; in_select = 1'b0;
         end
         if (inject && c == 3) start = 1'b0;
      end
   endtask

   task automatic check_cleared(input string tag);
      chk({tag, "_busy"},  8'({bsy1, bsy0}), 8'h0);
      chk({tag, "_valid"}, 8'({dv1, dv0}), 8'h0);
      chk({tag, "_done"},  8'({dn1, dn0}), 8'h0);
      chk({tag, "_out_s"}, 8'({os1, os0}), 8'h0);
      chk({tag, "_dig_count"}, 8'({dc1, dc0}), 8'h0);
      chk({tag, "_digits"}, {da1, db1, da0, db0}, 8'h0);
      chk({tag, "_dig_sel"}, 8'({ds1, ds0}), 8'h0);
   endtask

   initial begin
      logic [7:0] ra, rb;
      logic       rs;
      rst_n = 1'b0; start = 1'b0; in_a = 8'h00; in_b = 8'h00; in_select = 1'b0;
      @(negedge clk);
      check_cleared("reset");
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      run_op(8'hA5, 8'hA5, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, "t1_eq");
      run_op(8'hA5, 8'hA4, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, "t2_neq");
      run_op(8'h3C, 8'h3C, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, "t3_diff_same");
      run_op(8'h3C, 8'hBC, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, "t3_diff_top");
      run_op(8'h00, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 8'h00, 1'b0, "t4_ignore");
      run_op(8'h55, 8'h55, 1'b0, 1'b0, 1'b0, 1'b1, 8'h01, 8'h02, 1'b0, "t5_first");
      run_op(8'h01, 8'h02, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, "t5_second");

      for (int n = 0; n < 24; n++) begin
         ra = 8'($urandom);
         rs = 1'($urandom);
         case ($urandom_range(0, 2))
            0: rb = ra;
            1: rb = ra ^ (8'($urandom_range(1, 3)) << (2 * $urandom_range(0, 3)));
            default: rb = 8'($urandom);
         endcase
         run_op(ra, rb, rs, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, $sformatf("rnd%0d", n));
      end

      // Asynchronous reset in the middle of a scan.
      @(negedge clk);
      start = 1'b1; in_a = 8'hA5; in_b = 8'hA5; in_select = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      check_cleared("t6_async");
      @(negedge clk);
      rst_n = 1'b1;
      for (int c = 0; c < 6; c++) begin
         @(negedge clk);
         check_cleared($sformatf("t6_idle_c%0d", c));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
